// File: rtl/rd_capture_scheduler.sv
// rd_capture_scheduler: buffers read-command spacings and replays them as DQ capture windows
module rd_capture_scheduler #(
  parameter int DEPTH     = 8,
  parameter int GAP_W     = 5,
  parameter int BURST_LEN = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_write,
  input  logic [GAP_W-1:0]         gap_count,
  input  logic                     gap_valid,
  input  logic                     overflow,
  input  logic                     dqs_start,
  input  logic                     err_clr,
  output logic                     capture_en,
  output logic                     burst_start,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     drop_err,
  output logic                     spacing_err,
  output logic                     start_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = GAP_W + 1;

  typedef enum logic [1:0] {IDLE, BURST, SPACE} state_e;

  state_e           state_q, state_d;
  logic [EW-1:0]    cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             push_q, anc_q;
  logic [GAP_W:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             empty_q, full_q;
  logic             cap_q, bst_q, drop_q, spc_q, sta_q;
  logic             pop, push_ok, drop_set, spc_set, sta_set;
  logic             head_anc;
  logic [GAP_W-1:0] head_gap;
  logic [EW-1:0]    head_sp;

  assign head_anc = mem_q[rd_q][GAP_W];
  assign head_gap = mem_q[rd_q][GAP_W-1:0];
  assign head_sp  = {1'b0, head_gap} + EW'(1);
  assign push_ok  = push_q & (~full_q | pop);
  assign drop_set = push_q & full_q & ~pop;
  assign lvl_d    = lvl_q + LW'(push_ok) - LW'(pop);

  // Capture stage: remember whether this read must wait for its own dqs_start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q <= 1'b0;
      anc_q  <= 1'b0;
    end else begin
      push_q <= fifo_write;
      if (fifo_write) anc_q <= overflow | ~gap_valid;
    end
  end

  // Entry storage; a push into a full FIFO lands in the slot being popped
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= {anc_q, gap_count};
  end

  // FIFO pointers and registered occupancy flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wr_q    <= wr_q + AW'(push_ok);
      rd_q    <= rd_q + AW'(pop);
      lvl_q   <= lvl_d;
      empty_q <= lvl_d == '0;
      full_q  <= lvl_d == LW'(DEPTH);
    end
  end

  // Replay scheduler: every pop opens a window on the following cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? cnt_q : cnt_q + EW'(1);
    gap_d   = gap_q;
    pop     = 1'b0;
    spc_set = 1'b0;
    sta_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (dqs_start) begin
          pop     = ~empty_q;
          sta_set = empty_q;
          state_d = empty_q ? IDLE : BURST;
        end
      end
      BURST: begin
        sta_set = dqs_start;
        if (cnt_q == EW'(BURST_LEN - 1)) begin
          if (empty_q || head_anc) begin
            state_d = IDLE;
          end else if (head_sp <= EW'(BURST_LEN)) begin
            pop     = 1'b1;
            spc_set = head_sp < EW'(BURST_LEN);
          end else begin
            state_d = SPACE;
            gap_d   = head_gap;
          end
        end
      end
      SPACE: begin
        sta_set = dqs_start;
        if (cnt_q == {1'b0, gap_q}) begin
          pop     = 1'b1;
          state_d = BURST;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) cnt_d = '0;
  end

  // Scheduler state, elapsed counter relative to the last window start, held gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Registered window strobes and sticky errors (set wins over clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q  <= 1'b0;
      bst_q  <= 1'b0;
      drop_q <= 1'b0;
      spc_q  <= 1'b0;
      sta_q  <= 1'b0;
    end else begin
      cap_q  <= state_d == BURST;
      bst_q  <= pop;
      drop_q <= drop_set | (drop_q & ~err_clr);
      spc_q  <= spc_set | (spc_q & ~err_clr);
      sta_q  <= sta_set | (sta_q & ~err_clr);
    end
  end

  assign capture_en  = cap_q;
  assign burst_start = bst_q;
  assign fifo_empty  = empty_q;
  assign fifo_full   = full_q;
  assign fifo_level  = lvl_q;
  assign drop_err    = drop_q;
  assign spacing_err = spc_q;
  assign start_err   = sta_q;
endmodule

// File: tb/tb_rd_capture_scheduler.sv
// tb_rd_capture_scheduler: directed and random stimulus checked against a window-schedule model
module tb_rd_capture_scheduler;
  localparam int DEPTH = 8;
  localparam int GAP_W = 5;
  localparam int BL    = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             fifo_write = 1'b0;
  logic [GAP_W-1:0] gap_count = '0;
  logic             gap_valid = 1'b0;
  logic             overflow = 1'b0;
  logic             dqs_start = 1'b0;
  logic             err_clr = 1'b0;
  logic             capture_en, burst_start, fifo_empty, fifo_full;
  logic [$clog2(DEPTH):0] fifo_level;
  logic             drop_err, spacing_err, start_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic a; logic [GAP_W-1:0] g;} ent_t;
  ent_t q[$];
  bit   act, nv, pend, pend_a, m_drop, m_sp, m_st, e_bst, e_cap;
  int   s, nxt, n;

  rd_capture_scheduler #(.DEPTH(DEPTH), .GAP_W(GAP_W), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .fifo_write(fifo_write), .gap_count(gap_count),
    .gap_valid(gap_valid), .overflow(overflow), .dqs_start(dqs_start), .err_clr(err_clr),
    .capture_en(capture_en), .burst_start(burst_start), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .drop_err(drop_err),
    .spacing_err(spacing_err), .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    act = 0; nv = 0; pend = 0; pend_a = 0;
    m_drop = 0; m_sp = 0; m_st = 0; e_bst = 0; e_cap = 0;
  endtask

  // Windows are scheduled in absolute cycles: start times s, next start nxt = s + gap + 1
  task automatic model_step(input bit fw, input logic [GAP_W-1:0] gc, input bit gv, input bit ov,
                            input bit ds, input bit ec);
    bit pop = 0, sp = 0, st = 0, dr = 0;
    int sz = q.size();
    int g1;
    if (act) begin
      st = ds;
      if (nv) begin
        if (n + 1 == nxt) begin pop = 1; nv = 0; s = n + 1; end
      end else if (n == s + BL - 1) begin
        if (sz == 0) act = 0;
        else if (q[0].a) act = 0;
        else begin
          g1 = int'(q[0].g) + 1;
          if (g1 <= BL) begin pop = 1; s = n + 1; sp = g1 < BL; end
          else begin nv = 1; nxt = s + g1; end
        end
      end
    end else if (ds) begin
      if (sz > 0) begin pop = 1; act = 1; s = n + 1; end
      else st = 1;
    end
    if (pop) void'(q.pop_front());
    if (pend) begin
      if (sz < DEPTH || pop) q.push_back({pend_a, gc});
      else dr = 1;
    end
    pend   = fw;
    pend_a = ov | !gv;
    m_drop = dr | (m_drop & !ec);
    m_sp   = sp | (m_sp & !ec);
    m_st   = st | (m_st & !ec);
    e_bst  = pop;
    e_cap  = act && (n + 1 < s + BL);
    n++;
  endtask

  task automatic check_all();
    chk("cap", capture_en, e_cap);
    chk("bst", burst_start, e_bst);
    chk("lvl", fifo_level, q.size());
    chk("emp", fifo_empty, q.size() == 0);
    chk("full", fifo_full, q.size() == DEPTH);
    chk("drop", drop_err, m_drop);
    chk("spc", spacing_err, m_sp);
    chk("sta", start_err, m_st);
  endtask

  task automatic step(input bit fw, input logic [GAP_W-1:0] gc, input bit gv, input bit ov,
                      input bit ds, input bit ec);
    fifo_write = fw; gap_count = gc; gap_valid = gv; overflow = ov; dqs_start = ds; err_clr = ec;
    model_step(fw, gc, gv, ov, ds, ec);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, GAP_W'($urandom), 1, 0, 0, 0);
  endtask

  task automatic wr(input bit gv, input bit ov, input logic [GAP_W-1:0] g);
    step(1, GAP_W'($urandom), gv, ov, 0, 0);
    step(0, g, 1, 0, 0, 0);
  endtask

  task automatic dqs();
    step(0, '0, 1, 0, 1, 0);
  endtask

  task automatic clr();
    step(0, '0, 1, 0, 0, 1);
  endtask

  task automatic do_reset();
    fifo_write = 0; dqs_start = 0; err_clr = 0; overflow = 0;
    reset = 1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 0;
    check_all();
  endtask

  task automatic run(input int cycles, input int pfw, input int pds);
    logic [GAP_W-1:0] g;
    for (int i = 0; i < cycles; i++) begin
      g = ($urandom_range(0, 1) != 0) ? GAP_W'($urandom_range(4, 10)) : GAP_W'($urandom);
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, pfw - 1) == 0, g, $urandom_range(0, 15) != 0,
                $urandom_range(0, 15) == 0, pds != 0 && $urandom_range(0, pds - 1) == 0,
                $urandom_range(0, 49) == 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    reset = 0;
    n = 0;
    wr(0, 0, 0); idle(18); dqs(); idle(12);
    wr(0, 0, 0); idle(14); wr(1, 0, 15); idle(3); dqs(); idle(30);
    wr(0, 0, 0); idle(6); wr(1, 0, 7); idle(3); dqs(); idle(22);
    wr(0, 0, 0); idle(4); wr(1, 0, 5); idle(3); dqs(); idle(22); clr();
    wr(0, 0, 0); wr(1, 0, 31); idle(2); dqs(); idle(45);
    wr(0, 0, 0); wr(1, 1, 9); dqs(); idle(50); dqs(); idle(15);
    repeat (9) wr(1, 0, 10);
    clr(); idle(2);
    do_reset(); dqs(); idle(2); clr();
    wr(0, 0, 0); wr(1, 0, 20); dqs(); idle(12);
    do_reset();
    wr(0, 0, 0); wr(1, 0, 20); dqs(); idle(40);
    run(400, 3, 0);
    run(2500, 6, 30);
    run(2500, 3, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rd_capture_scheduler.md
Name: rd_capture_scheduler

Overview:
Read-path stage directly downstream of the read-command gap counter. Buffers each measured read-command spacing (gap, overflow and first-read flag) in a small FIFO. Replays those spacings on the read-data side: on a DQS-detected start it opens one capture window per buffered read, spaced exactly as the commands were issued. Its outputs feed the DQ capture/deserializer enables.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
GAP_W, 5, width of gap_count
BURST_LEN, 8, capture-window length in clk cycles (BL16 at 2 beats/clk)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
fifo_write  input  1  one-cycle pulse on each read command (rising edge of rddata_en)
gap_count  input  GAP_W  measured gap; updates on the clk edge that samples fifo_write
gap_valid  input  1  low until the first read command has been seen
overflow  input  1  gap counter saturated; cleared on the edge that samples fifo_write
dqs_start  input  1  one-cycle pulse from the preamble detector: first read data arriving
err_clr  input  1  clears sticky error flags
capture_en  output  1  capture window active
burst_start  output  1  one-cycle pulse on the first cycle of each window
fifo_empty  output  1  no buffered entries
fifo_full  output  1  DEPTH entries buffered
fifo_level  output  $clog2(DEPTH)+1  entry count
drop_err  output  1  sticky: push attempted while full
spacing_err  output  1  sticky: gap+1 < BURST_LEN on a replayed entry
start_err  output  1  sticky: dqs_start while busy or with FIFO empty

Behaviour:
- Reset (async, any time, including mid-burst): all outputs 0 except fifo_empty=1. FIFO is flushed. State goes to IDLE.
- Capture stage, in the fifo_write cycle:
  - register ovf_d = overflow and first_d = ~gap_valid.
  - set push_d = 1.
- Push stage, in the following cycle when push_d=1: write entry {anchor = ovf_d | first_d, gap = gap_count} (the gap_count sampled that cycle).
- Full FIFO on push: the entry is dropped and drop_err is set, unless a pop occurs in the same cycle, in which case the push succeeds.
- Simultaneous push and pop: allowed. fifo_level is unchanged.
- No bypass: an entry pushed in cycle T is poppable no earlier than T+1.
- All outputs are registered.
- FSM states: IDLE, BURST, SPACE. An elapsed counter is reset to 0 at each window start.
- IDLE:
  - dqs_start with FIFO non-empty: pop head (its gap is ignored) and go to BURST. capture_en=1 and burst_start=1 in the next cycle.
  - dqs_start with FIFO empty: ignored, set start_err.
- BURST:
  - capture_en=1 for exactly BURST_LEN cycles.
  - On the last cycle, peek head:
    - FIFO empty: go to IDLE.
    - head.anchor=1: go to IDLE. The entry is kept and waits for the next dqs_start.
    - head.gap+1 <= BURST_LEN: pop and restart BURST next cycle (back-to-back, no bubble). If gap+1 < BURST_LEN, also set spacing_err.
    - otherwise: go to SPACE holding head.gap (entry not yet popped).
- SPACE:
  - capture_en=0.
  - When elapsed == gap (relative to the previous window start S), pop; the new window starts at cycle S+gap+1.
- dqs_start in BURST or SPACE: ignored, set start_err.
- Sticky errors:
  - set on their condition, cleared by err_clr.
  - set has priority over clear in the same cycle.
- Gap arithmetic: gap+1 is computed in GAP_W+1 bits. Max gap 31 gives a spacing of 32.

Test Plan:
- Single read: fifo_write at T0 (gap_valid=0), dqs_start at T20 -> burst_start at T21; capture_en T21..T28; FIFO empty afterwards; no errors.
- Two reads with gap_count=15 (16-cycle spacing), dqs_start at T20 -> windows start at T21 and T37; capture_en low T29..T36.
- Back-to-back reads with gap=7 -> capture_en continuous for 16 cycles, two burst_start pulses 8 apart; spacing_err=0. Same test with gap=5 -> windows abut, spacing_err=1.
- Second read with overflow=1 -> first window only; state IDLE with 1 entry; second dqs_start 50 cycles later opens the second window one cycle after.
- 9 fifo_write pulses with DEPTH=8 and no dqs_start -> fifo_full=1, fifo_level=8, drop_err=1. Then err_clr -> drop_err=0. dqs_start while empty -> start_err=1.
- Assert reset during SPACE -> capture_en=0 and fifo_empty=1 immediately; after release, the first sequence replays correctly.
